// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with instruction decode, operand forwarding and
// load-use hazard detection for a small RV32-style integer pipeline.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    input  logic        flush,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [2:0]  ex_alucontrol,
    output logic [4:0]  ex_rd,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [31:0] ex_store_data,
    output logic        illegal
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;

    typedef enum logic [6:0] {
        OP_RTYPE = 7'b0110011,
        OP_ITYPE = 7'b0010011,
        OP_LOAD  = 7'b0000011,
        OP_STORE = 7'b0100011
    } opcode_e;

    // decode results for the incoming instruction
    logic    dec_legal;
    alu_op_e dec_alu;
    logic    dec_use_imm;
    logic    dec_regwrite;
    logic    dec_memread;
    logic    dec_memwrite;
    logic    dec_reads_rs1;
    logic    dec_reads_rs2;

    // ID/EX register contents
    logic        valid_q;
    alu_op_e     alu_q;
    logic [4:0]  rd_q;
    logic        regwrite_q;
    logic        memread_q;
    logic        memwrite_q;
    logic        use_imm_q;
    logic [4:0]  rs1_addr_q;
    logic [4:0]  rs2_addr_q;
    logic [31:0] rs1_data_q;
    logic [31:0] rs2_data_q;
    logic [31:0] imm_q;
    logic        illegal_q;

    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;

    // EX/MEM beats MEM/WB; x0 is never a forwarding target
    function automatic logic [31:0] fwd_select(
        input logic [4:0]  src,
        input logic [31:0] rf_val,
        input logic        em_we,
        input logic [4:0]  em_rd,
        input logic [31:0] em_val,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_val
    );
        logic [31:0] r;
        r = rf_val;
        if (src != '0) begin
            if (em_we && (em_rd == src))
                r = em_val;
            else if (mw_we && (mw_rd == src))
                r = mw_val;
        end
        return r;
    endfunction

    // decode opcode/funct fields into control; unknown encodings are illegal
    always_comb begin
        dec_legal     = 1'b0;
        dec_alu       = ALU_ADD;
        dec_use_imm   = 1'b0;
        dec_regwrite  = 1'b0;
        dec_memread   = 1'b0;
        dec_memwrite  = 1'b0;
        dec_reads_rs1 = 1'b0;
        dec_reads_rs2 = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_legal     = 1'b1;
                dec_regwrite  = 1'b1;
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: dec_alu = ALU_ADD;
                    {7'b0100000, 3'b000}: dec_alu = ALU_SUB;
                    {7'b0000000, 3'b111}: dec_alu = ALU_AND;
                    {7'b0000000, 3'b110}: dec_alu = ALU_OR;
                    {7'b0000000, 3'b010}: dec_alu = ALU_SLT;
                    {7'b0000001, 3'b000}: dec_alu = ALU_MUL;
                    default:              dec_legal = 1'b0;
                endcase
            end
            OP_ITYPE: begin
                dec_legal     = 1'b1;
                dec_regwrite  = 1'b1;
                dec_use_imm   = 1'b1;
                dec_reads_rs1 = 1'b1;
                case (funct3)
                    3'b000:  dec_alu = ALU_ADD;
                    3'b111:  dec_alu = ALU_AND;
                    3'b110:  dec_alu = ALU_OR;
                    3'b010:  dec_alu = ALU_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec_legal     = 1'b1;
                dec_regwrite  = 1'b1;
                dec_memread   = 1'b1;
                dec_use_imm   = 1'b1;
                dec_reads_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec_legal     = 1'b1;
                dec_memwrite  = 1'b1;
                dec_use_imm   = 1'b1;
                dec_reads_rs1 = 1'b1;
                dec_reads_rs2 = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
        // an illegal instruction reads nothing, so it can never cause a stall
        if (!dec_legal) begin
            dec_regwrite  = 1'b0;
            dec_memread   = 1'b0;
            dec_memwrite  = 1'b0;
            dec_reads_rs1 = 1'b0;
            dec_reads_rs2 = 1'b0;
        end
    end

    // load-use hazard: the load in EX produces a register the incoming op reads
    always_comb begin
        stall = 1'b0;
        if (!rst && !flush && valid_q && memread_q && (rd_q != '0) && in_valid) begin
            if ((dec_reads_rs1 && (rs1_addr == rd_q)) ||
                (dec_reads_rs2 && (rs2_addr == rd_q)))
                stall = 1'b1;
        end
    end

    // ID/EX register; flush or stall loads a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            alu_q      <= ALU_ADD;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            use_imm_q  <= 1'b0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            illegal_q  <= 1'b0;
        end else begin
            illegal_q <= in_valid && !dec_legal && !flush && !stall;
            if (flush || stall) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
                memread_q  <= 1'b0;
                memwrite_q <= 1'b0;
            end else begin
                valid_q    <= in_valid && dec_legal;
                regwrite_q <= in_valid && dec_regwrite;
                memread_q  <= in_valid && dec_memread;
                memwrite_q <= in_valid && dec_memwrite;
                alu_q      <= dec_alu;
                rd_q       <= rd_addr;
                use_imm_q  <= dec_use_imm;
                rs1_addr_q <= rs1_addr;
                rs2_addr_q <= rs2_addr;
                rs1_data_q <= rs1_data;
                rs2_data_q <= rs2_data;
                imm_q      <= imm;
            end
        end
    end

    // forwarding muxes on the registered sources feed the ALU directly
    always_comb begin
        rs1_fwd = fwd_select(rs1_addr_q, rs1_data_q, exmem_regwrite, exmem_rd, exmem_result,
                             memwb_regwrite, memwb_rd, memwb_result);
        rs2_fwd = fwd_select(rs2_addr_q, rs2_data_q, exmem_regwrite, exmem_rd, exmem_result,
                             memwb_regwrite, memwb_rd, memwb_result);
        ex_a          = rs1_fwd;
        ex_b          = use_imm_q ? imm_q : rs2_fwd;
        ex_store_data = rs2_fwd;
    end

    assign ex_valid      = valid_q;
    assign ex_alucontrol = alu_q;
    assign ex_rd         = rd_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_memread    = memread_q;
    assign ex_memwrite   = memwrite_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes expected EX-side outputs
// computed by a reference model; a negedge monitor pops and compares.
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
    } ins_t;

    typedef struct packed {
        logic        exw;
        logic [4:0]  exrd;
        logic [31:0] exres;
        logic        mww;
        logic [4:0]  mwrd;
        logic [31:0] mwres;
    } fw_t;

    typedef struct packed {
        logic        stall;
        logic        valid;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        ill;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, flush;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic [31:0] rs1_data, rs2_data, imm;
    logic exmem_regwrite, memwb_regwrite;
    logic [4:0] exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic stall, ex_valid, ex_regwrite, ex_memread, ex_memwrite, illegal;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [2:0] ex_alucontrol;
    logic [4:0] ex_rd;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
        .ex_alucontrol(ex_alucontrol), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data),
        .illegal(illegal)
    );

    int total = 0;
    int bad = 0;
    exp_t sb[$];

    // reference model state: what the stage should hold after the last edge
    bit   m_valid, m_rw, m_mr, m_mw, m_imm, m_ill;
    logic [2:0] m_alu;
    ins_t m_ins;
    bit   last_stall;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    // instruction semantics taken straight from the ISA subset table
    function automatic void ref_decode(input ins_t i, output bit legal, output logic [2:0] alu,
                                       output bit r1, output bit r2, output bit ib,
                                       output bit mr, output bit mw, output bit rw);
        legal = 0; alu = 3'd0; r1 = 0; r2 = 0; ib = 0; mr = 0; mw = 0; rw = 0;
        if (i.op == 7'b0110011) begin
            legal = 1; r1 = 1; r2 = 1; rw = 1;
            if      (i.f7 == 7'b0000000 && i.f3 == 3'b000) alu = 3'd0;
            else if (i.f7 == 7'b0100000 && i.f3 == 3'b000) alu = 3'd1;
            else if (i.f7 == 7'b0000000 && i.f3 == 3'b111) alu = 3'd2;
            else if (i.f7 == 7'b0000000 && i.f3 == 3'b110) alu = 3'd3;
            else if (i.f7 == 7'b0000000 && i.f3 == 3'b010) alu = 3'd5;
            else if (i.f7 == 7'b0000001 && i.f3 == 3'b000) alu = 3'd4;
            else legal = 0;
        end else if (i.op == 7'b0010011) begin
            legal = 1; r1 = 1; ib = 1; rw = 1;
            if      (i.f3 == 3'b000) alu = 3'd0;
            else if (i.f3 == 3'b111) alu = 3'd2;
            else if (i.f3 == 3'b110) alu = 3'd3;
            else if (i.f3 == 3'b010) alu = 3'd5;
            else legal = 0;
        end else if (i.op == 7'b0000011) begin
            legal = 1; r1 = 1; ib = 1; mr = 1; rw = 1;
        end else if (i.op == 7'b0100011) begin
            legal = 1; r1 = 1; r2 = 1; ib = 1; mw = 1;
        end
        if (!legal) begin
            r1 = 0; r2 = 0; mr = 0; mw = 0; rw = 0;
        end
    endfunction

    // value of a source register as seen by the ALU this cycle
    function automatic logic [31:0] src_val(logic [4:0] a, logic [31:0] rf, fw_t f);
        if (a == 5'd0) return rf;
        if (f.exw && f.exrd == a) return f.exres;
        if (f.mww && f.mwrd == a) return f.mwres;
        return rf;
    endfunction

    function automatic ins_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [4:0] rs1,
                                logic [4:0] rs2, logic [4:0] rd, logic [31:0] d1,
                                logic [31:0] d2, logic [31:0] im);
        ins_t i;
        i.v = 1'b1; i.op = op; i.f3 = f3; i.f7 = f7; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        i.d1 = d1; i.d2 = d2; i.imm = im;
        return i;
    endfunction

    function automatic fw_t mkfw(logic ew, logic [4:0] er, logic [31:0] ev,
                                 logic mwe, logic [4:0] mr, logic [31:0] mv);
        fw_t f;
        f.exw = ew; f.exrd = er; f.exres = ev; f.mww = mwe; f.mwrd = mr; f.mwres = mv;
        return f;
    endfunction

    task automatic drive(input ins_t i, input fw_t f, input bit fl);
        in_valid = i.v; opcode = i.op; funct3 = i.f3; funct7 = i.f7;
        rs1_addr = i.rs1; rs2_addr = i.rs2; rd_addr = i.rd;
        rs1_data = i.d1; rs2_data = i.d2; imm = i.imm;
        exmem_regwrite = f.exw; exmem_rd = f.exrd; exmem_result = f.exres;
        memwb_regwrite = f.mww; memwb_rd = f.mwrd; memwb_result = f.mwres;
        flush = fl;
    endtask

    function automatic void model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_imm = 0; m_ill = 0;
        m_alu = 3'd0; m_ins = '0; last_stall = 0;
    endfunction

    // one cycle: called at posedge+1, leaves at the next posedge+1
    task automatic step(input ins_t i, input fw_t f, input bit fl);
        exp_t e;
        bit lg, r1, r2, ib, mr, mw, rw;
        logic [2:0] al;
        drive(i, f, fl);
        ref_decode(i, lg, al, r1, r2, ib, mr, mw, rw);
        e.stall = !fl && m_valid && m_mr && (m_ins.rd != 5'd0) && i.v &&
                  ((r1 && i.rs1 == m_ins.rd) || (r2 && i.rs2 == m_ins.rd));
        e.valid = m_valid;
        e.rw    = m_valid && m_rw;
        e.mr    = m_valid && m_mr;
        e.mw    = m_valid && m_mw;
        e.ill   = m_ill;
        e.alu   = m_alu;
        e.rd    = m_ins.rd;
        e.a     = src_val(m_ins.rs1, m_ins.d1, f);
        e.b     = m_imm ? m_ins.imm : src_val(m_ins.rs2, m_ins.d2, f);
        e.sd    = src_val(m_ins.rs2, m_ins.d2, f);
        sb.push_back(e);
        @(posedge clk);
        #1;
        m_ill = i.v && !lg && !fl;
        if (fl || e.stall || !i.v || !lg) begin
            m_valid = 0;
        end else begin
            m_valid = 1; m_ins = i; m_alu = al; m_rw = rw; m_mr = mr; m_mw = mw; m_imm = ib;
        end
        last_stall = e.stall;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_valid"}, ex_valid, 0);
        chk({tag, "_regwrite"}, ex_regwrite, 0);
        chk({tag, "_memread"}, ex_memread, 0);
        chk({tag, "_memwrite"}, ex_memwrite, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_alu"}, ex_alucontrol, 0);
        chk({tag, "_rd"}, ex_rd, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_a"}, ex_a, 0);
        chk({tag, "_b"}, ex_b, 0);
        chk({tag, "_sd"}, ex_store_data, 0);
    endtask

    function automatic ins_t rnd_ins();
        ins_t i;
        int k;
        k = $urandom_range(0, 12);
        i = mk(7'b0110011, 3'b000, 7'b0000000, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
        case (k)
            1:  i.f7 = 7'b0100000;
            2:  i.f3 = 3'b111;
            3:  i.f3 = 3'b110;
            4:  i.f3 = 3'b010;
            5:  i.f7 = 7'b0000001;
            6:  begin i.op = 7'b0010011; i.f3 = 3'b000; i.f7 = 7'($urandom); end
            7:  begin i.op = 7'b0010011; i.f3 = 3'b111; i.f7 = 7'($urandom); end
            8:  begin i.op = 7'b0010011; i.f3 = 3'b010; i.f7 = 7'($urandom); end
            9:  begin i.op = 7'b0000011; i.f3 = 3'($urandom); end
            10: begin i.op = 7'b0100011; i.f3 = 3'($urandom); end
            11: begin i.op = 7'b0010011; i.f3 = 3'b110; end
            12: begin i.op = 7'($urandom); i.f3 = 3'($urandom); i.f7 = 7'($urandom); end
            default: ;
        endcase
        i.v = ($urandom_range(0, 9) != 0);
        return i;
    endfunction

    // monitor: every negedge with an outstanding expectation is compared
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall", stall, e.stall);
            chk("ex_valid", ex_valid, e.valid);
            chk("ex_regwrite", ex_regwrite, e.rw);
            chk("ex_memread", ex_memread, e.mr);
            chk("ex_memwrite", ex_memwrite, e.mw);
            chk("illegal", illegal, e.ill);
            if (e.valid) begin
                chk("ex_alucontrol", ex_alucontrol, e.alu);
                chk("ex_rd", ex_rd, e.rd);
                chk("ex_a", ex_a, e.a);
                chk("ex_b", ex_b, e.b);
                chk("ex_store_data", ex_store_data, e.sd);
            end
        end
    end

    initial begin
        ins_t idle, i_add, i_sub, i_lw, i_use, i_addi0, i_bad, prev, cur;
        fw_t none, f;
        bit fl;

        none = '0;
        idle = '0;
        i_add   = mk(7'b0110011, 3'b000, 7'b0000000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        i_sub   = mk(7'b0110011, 3'b000, 7'b0100000, 5'd3, 5'd1, 5'd4, 32'd1, 32'd2, 32'd0);
        i_lw    = mk(7'b0000011, 3'b010, 7'b0000000, 5'd1, 5'd0, 5'd5, 32'd100, 32'd0, 32'd0);
        i_use   = mk(7'b0110011, 3'b000, 7'b0000000, 5'd5, 5'd2, 5'd6, 32'd0, 32'd3, 32'd0);
        i_addi0 = mk(7'b0010011, 3'b000, 7'b0000000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd5);
        i_bad   = mk(7'b0110011, 3'b111, 7'b0100000, 5'd1, 5'd2, 5'd7, 32'd1, 32'd2, 32'd0);

        rst = 1'b1;
        drive(idle, none, 0);
        model_reset();
        #2;
        chk_reset("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // plain add, no forwarding
        step(i_add, none, 0);
        step(idle, none, 0);
        // sub with both forwarding sources matching: EX/MEM wins
        step(i_sub, none, 0);
        step(idle, mkfw(1, 5'd3, 32'd12, 1, 5'd3, 32'd99), 0);
        // load-use: one stall, one bubble, then forwarded from MEM/WB
        step(i_lw, none, 0);
        step(i_use, none, 0);
        step(i_use, none, 0);
        step(idle, mkfw(0, 5'd0, 32'd0, 1, 5'd5, 32'h0000_ABCD), 0);
        // x0 source is never forwarded
        step(i_addi0, none, 0);
        step(idle, mkfw(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF), 0);
        // illegal R-type encoding: single-cycle pulse and a bubble
        step(i_bad, none, 0);
        step(idle, none, 0);
        step(idle, none, 0);
        // flush on top of a load-use hazard
        step(i_lw, none, 0);
        step(i_use, none, 1);
        step(i_use, none, 0);
        step(idle, none, 0);
        // asynchronous reset while a stall is being signalled
        step(i_lw, none, 0);
        drive(i_use, none, 0);
        #1;
        chk("pre_reset_stall", stall, 1);
        rst = 1'b1;
        #1;
        chk_reset("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step(i_use, none, 0);
        step(idle, none, 0);

        // randomized traffic with held instructions on stall
        prev = idle;
        for (int n = 0; n < 400; n++) begin
            cur = last_stall ? prev : rnd_ins();
            f = mkfw(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                     1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            fl = ($urandom_range(0, 11) == 0);
            step(cur, f, fl);
            prev = cur;
        end
        step(idle, none, 0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have decode inputs: in_valid 1; opcode 7; funct3 3; funct7 7; rs1_addr, rs2_addr, rd_addr 5 each; rs1_data, rs2_data, imm 32 each (imm pre-sign-extended).
REQ-003 SHALL have forwarding inputs: exmem_regwrite 1, exmem_rd 5, exmem_result 32; memwb_regwrite 1, memwb_rd 5, memwb_result 32.
REQ-004 SHALL have control input flush 1, which squashes the incoming instruction.
REQ-005 SHALL have outputs: stall 1, hold to IF/ID; ex_valid 1; ex_a, ex_b 32, ALU operands; ex_alucontrol 3; ex_rd 5; ex_regwrite, ex_memread, ex_memwrite 1; ex_store_data 32; illegal 1, registered one-cycle pulse.

Function
REQ-006 SHALL decode alucontrol as: 000 add, 001 sub, 010 and, 011 or, 100 mul, 101 set-less-than (sign bit of a-b, zero-extended).
REQ-007 SHALL decode opcode 0110011 (R-type, reads rs1 and rs2) by funct7/funct3: 0000000/000 add, 0100000/000 sub, 0000000/111 and, 0000000/110 or, 0000000/010 slt, 0000001/000 mul; sets regwrite.
REQ-008 SHALL decode opcode 0010011 (I-type, reads rs1 only) by funct3: 000 add, 111 and, 110 or, 010 slt; operand b = imm; sets regwrite.
REQ-009 SHALL decode 0000011 (load) as add with b = imm, memread=1, regwrite=1; and 0100011 (store) as add with b = imm, memwrite=1, regwrite=0, reading rs2 for store data.
REQ-010 SHALL treat any other opcode/funct combination with in_valid=1 as illegal: insert a bubble and pulse illegal for exactly one cycle.
REQ-011 SHALL, on each rising clk edge with stall=0 and flush=0, register the decoded fields, rs1/rs2 addresses and data, and imm; ex_valid <= in_valid and not illegal.
REQ-012 SHALL make the bubble state ex_valid=0 with regwrite=0, memread=0 and memwrite=0; data fields are don't-care.
REQ-013 SHALL compute ex_a, ex_b and ex_store_data combinationally from the registered state through the forwarding muxes, giving zero added latency to the ALU.
REQ-014 SHALL forward exmem_result when exmem_regwrite=1, exmem_rd!=0 and exmem_rd equals the registered source address.
REQ-015 SHALL otherwise forward memwb_result under the same conditions; EX/MEM has priority over MEM/WB.
REQ-016 SHALL otherwise use the registered register-file data; x0 is never forwarded.
REQ-017 SHALL never forward into ex_b for I-type, load or store, where ex_b = registered imm; ex_store_data SHALL use the forwarded rs2.
REQ-018 SHALL assert stall combinationally on a load-use hazard: ex_valid=1, ex_memread=1, ex_rd!=0, in_valid=1, and ex_rd equals an rs field the incoming instruction actually reads.
REQ-019 SHALL, while stall=1, load a bubble into the register; the upstream instruction is held and re-presented on the next cycle.
REQ-020 SHALL give flush priority over stall: flush=1 forces stall=0, loads a bubble and suppresses illegal.
REQ-021 SHALL keep stall at most one cycle per load-use pair, because the bubble clears the hazard condition.

Reset
REQ-022 SHALL, while rst=1 (asynchronous), drive ex_valid=0, ex_regwrite=0, ex_memread=0, ex_memwrite=0, illegal=0, ex_alucontrol=000, ex_rd=0 and all registered data to 0.
REQ-023 SHALL drive stall=0 during reset.
REQ-024 SHALL, if rst asserts mid-stall, clear the held hazard; the first edge after release captures the presented instruction normally.

Verification
REQ-025 Bench SHALL cover these directed scenarios:
- add x3,x1,x2, rs1_data=5, rs2_data=7, no forwarding -> next cycle ex_a=5, ex_b=7, alucontrol=000, ex_rd=3, ex_regwrite=1.
- sub x4,x3,x1 with exmem_rd=3, exmem_result=12 and memwb_rd=3, memwb_result=99 -> ex_a=12 (EX/MEM wins), alucontrol=001.
- lw x5,0(x1) followed by add x6,x5,x2 -> stall=1 for one cycle, one bubble (ex_valid=0), then add enters with ex_a taken from the forward path.
- addi x0-target with exmem_rd=0, exmem_regwrite=1, exmem_result=0xFFFF_FFFF, reading rs1=x0 -> ex_a=0 (no x0 forwarding).
- opcode 0110011, funct7=0100000, funct3=111 -> illegal=1 for one cycle, ex_valid=0.
- flush=1 coincident with a load-use hazard -> stall=0, bubble loaded; rst pulse mid-stream -> all outputs at reset values immediately, asynchronously.
